// File: rtl/ttl_gen_sched_pkg.sv
// Shared types and defaults for the ttl_gen transaction scheduler.
package ttl_gen_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES    = 1024;
    localparam int unsigned DEF_INIT_PULSE_CYCLES = 2;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ttl_gen_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above i_ptr and wraps around.
module ttl_gen_rr_arbiter
    import ttl_gen_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [grant_w(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [grant_w(NUM_REQ)-1:0] o_grant_idx
);

    localparam int unsigned GW = grant_w(NUM_REQ);

    logic          w_found;
    logic [GW:0]   w_sum;
    logic [GW-1:0] w_idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            // The sum stays below 2*NUM_REQ, so a single conditional subtract wraps it.
            w_sum = {1'b0, i_ptr} + (GW+1)'(i);
            if (w_sum >= (GW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (GW+1)'(NUM_REQ);
            end
            w_idx = w_sum[GW-1:0];
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/ttl_gen_txn_sched.sv
// Round-robin scheduler sharing one ttl_gen_axi master between NUM_REQ requesters.
// Define TTL_GEN_SCHED_RETRY_EN to reissue a failed transaction up to RETRY_MAX times.
module ttl_gen_txn_sched
    import ttl_gen_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned INIT_PULSE_CYCLES = DEF_INIT_PULSE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RETRY_MAX         = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        ack_err,
    output logic [grant_w(NUM_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic                        m_init_axi_txn,
    input  logic                        m_txn_done,
    input  logic                        m_error,
    output logic                        timeout_sticky
);

    localparam int unsigned GW = grant_w(NUM_REQ);
    localparam int unsigned PW = $clog2(INIT_PULSE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    logic [GW-1:0]      r_ptr;
    logic [GW-1:0]      r_grant_id;
    logic [NUM_REQ-1:0] r_grant_oh;
    logic [PW-1:0]      r_pulse_cnt;
    logic [TW-1:0]      r_to_cnt;
    logic               r_armed;
    logic               r_busy;
    logic               r_init;
    logic [NUM_REQ-1:0] r_ack;
    logic               r_ack_err;
    logic               r_sticky;

    logic [NUM_REQ-1:0] w_grant_oh;
    logic [GW-1:0]      w_grant_idx;
    logic               w_done;
    logic               w_timeout;
    logic               w_fail;
    logic               w_retry;

    ttl_gen_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req       (req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant_oh),
        .o_grant_idx (w_grant_idx)
    );

    // Only a DONE seen after a low sample counts; a stale high from the last txn is ignored.
    assign w_done    = r_armed && m_txn_done;
    assign w_timeout = !w_done && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_fail    = w_done ? m_error : 1'b1;

`ifdef TTL_GEN_SCHED_RETRY_EN
    localparam int unsigned RW = $clog2(RETRY_MAX + 2);
    logic [RW-1:0] r_retry_cnt;

    assign w_retry = w_fail && (r_retry_cnt < RW'(RETRY_MAX));

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_retry_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_retry_cnt <= '0;
        end else if (r_state == WAIT && (w_done || w_timeout) && w_retry) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_retry_max;
    assign w_unused_retry_max = RETRY_MAX;
    assign w_retry            = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_ptr       <= GW'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_grant_oh  <= '0;
            r_pulse_cnt <= '0;
            r_to_cnt    <= '0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
            r_init      <= 1'b0;
            r_ack       <= '0;
            r_ack_err   <= 1'b0;
            r_sticky    <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_state     <= INIT;
                        r_grant_id  <= w_grant_idx;
                        r_grant_oh  <= w_grant_oh;
                        r_ptr       <= w_grant_idx;
                        r_busy      <= 1'b1;
                        r_init      <= 1'b1;
                        r_pulse_cnt <= '0;
                        r_armed     <= 1'b0;
                    end
                end
                INIT: begin
                    if (r_pulse_cnt == PW'(INIT_PULSE_CYCLES - 1)) begin
                        r_state  <= WAIT;
                        r_init   <= 1'b0;
                        r_to_cnt <= '0;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (!m_txn_done) begin
                        r_armed <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_sticky <= 1'b1;
                    end
                    if (w_done || w_timeout) begin
                        if (w_retry) begin
                            r_state     <= INIT;
                            r_init      <= 1'b1;
                            r_pulse_cnt <= '0;
                            r_armed     <= 1'b0;
                        end else begin
                            r_state   <= RESP;
                            r_ack     <= r_grant_oh;
                            r_ack_err <= w_fail;
                        end
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack            = r_ack;
    assign ack_err        = r_ack_err;
    assign grant_id       = r_grant_id;
    assign busy           = r_busy;
    assign m_init_axi_txn = r_init;
    assign timeout_sticky = r_sticky;

endmodule

// File: doc/ttl_gen_txn_sched.md
Name: ttl_gen_txn_sched

Overview:
Round-robin scheduler that shares the single ttl_gen_axi M00_AXI master between NUM_REQ requesters. Each accepted request:
- pulses the master's INIT_AXI_TXN;
- waits for TXN_DONE;
- samples ERROR;
- returns a one-cycle ack with status to the granted requester.

A watchdog aborts transactions the master never completes. The block sits between the TTL sequencing logic and the ttl_gen_axi master port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INIT_PULSE_CYCLES, 2, width of the init pulse in ACLK cycles (>=1)
TIMEOUT_CYCLES, 1024, maximum cycles allowed in WAIT before abort
RETRY_MAX, 2, reissues per request on error or timeout (used only with the optional feature)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
req  in  NUM_REQ  level requests; held high until the matching ack
ack  out  NUM_REQ  one-hot, one-cycle completion pulse
ack_err  out  1  valid with ack; 1 = master ERROR or timeout
grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served
busy  out  1  high in every state except IDLE
m_init_axi_txn  out  1  to master INIT_AXI_TXN
m_txn_done  in  1  from master TXN_DONE (level; stays high until the next init)
m_error  in  1  from master ERROR
timeout_sticky  out  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (asynchronous, takes effect immediately): all outputs 0, state IDLE, RR pointer = NUM_REQ-1 (first search starts at requester 0), counters 0. A reset mid-transaction drops m_init_axi_txn in the same instant and issues no ack.
- IDLE: if any req bit is high, capture the grant and go to INIT on the next cycle. grant_id and busy update in that same cycle.
- Arbitration: search upward from pointer+1 and wrap around. The first set bit wins. The pointer updates to the winner when the grant is captured. req is sampled only in IDLE.
- INIT: m_init_axi_txn = 1 for exactly INIT_PULSE_CYCLES cycles, then go to WAIT.
- WAIT: an armed flag clears on entry to INIT and sets once m_txn_done is sampled low. Completion is m_txn_done high while armed, which avoids false completion on stale DONE from the previous transaction.
  - On completion, sample m_error and go to RESP.
  - A timeout counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES-1 without completion: set timeout_sticky, record err = 1, go to RESP.
  - Simultaneous completion and timeout: completion wins; timeout_sticky is not set.
- RESP: ack[grant_id] = 1 and ack_err = err for one cycle, then IDLE.
  - Minimum request-to-ack latency: 1 (IDLE) + INIT_PULSE_CYCLES + 2 (minimum WAIT: DONE low, then high) + 1 = 6 cycles with defaults.
- Deasserting req after the grant does not abort: the transaction completes and ack is still pulsed.
- ack_err is 0 whenever ack is 0. At most one ack bit is high in any cycle.
- Back-to-back: the cycle after RESP is IDLE, so the next grant occurs at the earliest 2 cycles after the previous ack.

Optional Feature:
TTL_GEN_SCHED_RETRY_EN
- Defined: on err (m_error=1 or timeout), while retry_cnt < RETRY_MAX, increment retry_cnt and go back to INIT with the same grant_id, with no ack in between. ack_err=1 only after RETRY_MAX+1 failed attempts. retry_cnt clears on each new grant.
- Undefined: no retry logic; the first error is reported directly. The RETRY_MAX parameter is ignored.

Decomposition:
- ttl_gen_sched_pkg contains:
  - state enum: IDLE, INIT, WAIT, RESP;
  - width function for grant_id;
  - default constants for the timeout and the pulse width.
- Sub-module ttl_gen_rr_arbiter (parameter NUM_REQ): inputs req and pointer; outputs a one-hot grant and its index. Purely combinational.
- The FSM, counters and the armed flag stay in the top module.

Test Plan:
- req=4'b0001; master asserts DONE 3 cycles after the init pulse ends, ERROR=0 -> init high exactly 2 cycles; ack=4'b0001, ack_err=0; busy back to 0 one cycle after ack.
- req=4'b1111 held, each ack then that bit's req dropped -> grants in order 0,1,2,3; no requester is granted twice before all four are served.
- DONE held high from the previous transaction when the next init starts -> no ack until DONE has gone low and then high again.
- DONE never asserted, TIMEOUT_CYCLES=16 -> ack with ack_err=1 at least 16 WAIT cycles after entry; timeout_sticky=1 until reset.
- ARESET pulsed during WAIT -> m_init_axi_txn, busy, ack, grant_id all 0 immediately; a fresh request afterwards is granted to requester 0 first.
- With TTL_GEN_SCHED_RETRY_EN and ERROR=1 on every attempt -> 3 init pulses for requester 2, then a single ack[2] with ack_err=1.
